// File: rtl/alu_pkg.sv
// Shared widths and output-stage state encoding for the ALU issue block.
package alu_pkg;

  localparam int unsigned AluWidth    = 8;
  localparam int unsigned AluMulWidth = 16;
  localparam int unsigned OpselWidth  = 3;

  typedef enum logic {
    ResEmpty = 1'b0,
    ResFull  = 1'b1
  } res_state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO: power-of-two storage with naturally wrapping pointers and an occupancy count.
module alu_cmd_fifo #(
  parameter int unsigned DataWidth = 19,
  parameter int unsigned Depth     = 4,
  localparam int unsigned CntWidth = $clog2(Depth + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DataWidth-1:0] wdata,
  output logic [DataWidth-1:0] rdata,
  output logic [CntWidth-1:0]  count,
  output logic                 full,
  output logic                 empty
);

  localparam int unsigned PtrWidth = $clog2(Depth);

  logic [DataWidth-1:0] mem_q [Depth];
  logic [PtrWidth-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntWidth-1:0]  count_q, count_d;
  logic                 push_ok, pop_ok;

  assign full    = (count_q == CntWidth'(Depth));
  assign empty   = (count_q == '0);
  // A full FIFO refuses a push even when a pop frees a slot on the same edge.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntWidth'(1);
      2'b01:   count_d = count_q - CntWidth'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrWidth'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/alu_issue.sv
// Issues queued commands to an external combinational ALU and holds each result in a
// single output register until the consumer takes it.
module alu_issue
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH     = AluWidth,
  parameter int unsigned MUL_WIDTH = AluMulWidth,
  parameter int unsigned DEPTH     = 4,
  localparam int unsigned CntWidth = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [WIDTH-1:0]      cmd_a,
  input  logic [WIDTH-1:0]      cmd_b,
  input  logic [OpselWidth-1:0] cmd_opsel,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  output logic [OpselWidth-1:0] alu_opsel,
  input  logic [MUL_WIDTH-1:0]  alu_result,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [MUL_WIDTH-1:0]  res_data,
  output logic [OpselWidth-1:0] res_opsel,
  output logic [CntWidth-1:0]   count
);

  localparam int unsigned EntryWidth = 2 * WIDTH + OpselWidth;

  logic [EntryWidth-1:0] head;
  logic                  full, empty, push, issue;
  res_state_e            state_q, state_d;
  logic [MUL_WIDTH-1:0]  res_data_q;
  logic [OpselWidth-1:0] res_opsel_q;

  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  // Issue when there is work and the result slot is free or being freed this edge.
  assign issue     = !empty && ((state_q == ResEmpty) || res_ready);

  alu_cmd_fifo #(
    .DataWidth (EntryWidth),
    .Depth     (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (issue),
    .wdata ({cmd_a, cmd_b, cmd_opsel}),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    alu_a     = '0;
    alu_b     = '0;
    alu_opsel = '0;
    if (!empty) begin
      {alu_a, alu_b, alu_opsel} = head;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ResEmpty: if (issue) state_d = ResFull;
      ResFull:  if (!issue && res_ready) state_d = ResEmpty;
      default:  state_d = ResEmpty;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ResEmpty;
      res_data_q  <= '0;
      res_opsel_q <= '0;
    end else begin
      state_q <= state_d;
      if (issue) begin
        res_data_q  <= alu_result;
        res_opsel_q <= alu_opsel;
      end
    end
  end

  assign res_valid = (state_q == ResFull);
  assign res_data  = res_data_q;
  assign res_opsel = res_opsel_q;

endmodule

// File: tb/tb_alu_issue.sv
// Randomized bench for alu_issue: queue-based reference model plus a scoreboard monitor.
module tb_alu_issue;

  localparam int unsigned W  = 8;
  localparam int unsigned MW = 16;
  localparam int unsigned D  = 4;
  localparam int unsigned CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [W-1:0]  cmd_a = '0;
  logic [W-1:0]  cmd_b = '0;
  logic [2:0]    cmd_opsel = '0;
  logic [W-1:0]  alu_a, alu_b;
  logic [2:0]    alu_opsel;
  logic [MW-1:0] alu_result;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [MW-1:0] res_data;
  logic [2:0]    res_opsel;
  logic [CW-1:0] count;

  alu_issue #(
    .WIDTH     (W),
    .MUL_WIDTH (MW),
    .DEPTH     (D)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_opsel  (cmd_opsel),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opsel  (alu_opsel),
    .alu_result (alu_result),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_opsel  (res_opsel),
    .count      (count)
  );

  // ALU stub: plain product at full result width.
  assign alu_result = MW'(alu_a) * MW'(alu_b);

  always #5 clk = ~clk;

  typedef struct packed {logic [W-1:0] a; logic [W-1:0] b; logic [2:0] op;} cmd_t;
  typedef struct packed {logic [MW-1:0] data; logic [2:0] op;} res_t;

  cmd_t m_fifo[$];
  res_t sb_q[$];
  cmd_t m_head;
  res_t m_res = '0;
  res_t sb_exp;
  res_t prev_res = '0;
  bit   m_held = 1'b0;
  bit   m_issue, m_push;
  bit   prev_stall = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   n_res = 0;
  int   base;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a command queue plus one result slot, updated at each clock edge.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_fifo.delete();
      sb_q.delete();
      m_held = 1'b0;
      m_res  = '0;
    end else begin
      m_issue = (m_fifo.size() != 0) && (!m_held || res_ready);
      m_push  = cmd_valid && (m_fifo.size() < D);
      if (m_issue) begin
        m_head = m_fifo.pop_front();
        m_res  = {MW'(m_head.a) * MW'(m_head.b), m_head.op};
        m_held = 1'b1;
      end else if (res_ready) begin
        m_held = 1'b0;
      end
      if (m_push) begin
        m_fifo.push_back({cmd_a, cmd_b, cmd_opsel});
        sb_q.push_back({MW'(cmd_a) * MW'(cmd_b), cmd_opsel});
      end
    end
  end

  // Monitor: compares state against the model and pops the scoreboard on each handshake.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      check("count", 32'(count), 32'(m_fifo.size()));
      check("cmd_ready", 32'(cmd_ready), 32'(m_fifo.size() < D));
      check("res_valid", 32'(res_valid), 32'(m_held));
      check("res_reg", 32'({res_data, res_opsel}), 32'(m_res));
      if (m_fifo.size() != 0) check("alu_head", 32'({alu_a, alu_b, alu_opsel}), 32'(m_fifo[0]));
      else check("alu_idle", 32'({alu_a, alu_b, alu_opsel}), 32'd0);
      if (prev_stall) begin
        check("stall_valid", 32'(res_valid), 32'd1);
        check("stall_hold", 32'({res_data, res_opsel}), 32'(prev_res));
      end
      if (res_valid && res_ready) begin
        check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          sb_exp = sb_q.pop_front();
          check("sb_data", 32'(res_data), 32'(sb_exp.data));
          check("sb_opsel", 32'(res_opsel), 32'(sb_exp.op));
        end
        n_res++;
      end
      prev_stall = res_valid && !res_ready;
      prev_res   = {res_data, res_opsel};
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_cmd(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] op);
    cmd_valid = v;
    cmd_a     = a;
    cmd_b     = b;
    cmd_opsel = op;
  endtask

  task automatic drain(input int max_cycles);
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < max_cycles && (res_valid || count != '0); i++) step();
    check("drain_valid", 32'(res_valid), 32'd0);
    check("drain_count", 32'(count), 32'd0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_data", 32'({res_data, res_opsel}), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    step();
    step();
    rst_n = 1'b1;

    // Single command into an idle block.
    res_ready = 1'b1;
    set_cmd(1'b1, 8'd12, 8'd10, 3'd2);
    step();
    cmd_valid = 1'b0;
    check("single_lat0", 32'(res_valid), 32'd0);
    step();
    check("single_valid", 32'(res_valid), 32'd1);
    check("single_data", 32'(res_data), 32'd120);
    check("single_opsel", 32'(res_opsel), 32'd2);
    step();

    // Back-pressure: five accepted, sixth refused.
    res_ready = 1'b0;
    base = n_res;
    for (int i = 0; i < 6; i++) begin
      set_cmd(1'b1, W'(i + 1), W'(i + 3), 3'(i));
      step();
    end
    check("fill_count", 32'(count), 32'd4);
    check("fill_ready", 32'(cmd_ready), 32'd0);
    check("fill_held", 32'(res_valid), 32'd1);
    drain(12);
    check("fill_results", 32'(n_res - base), 32'd5);

    // Stream of eight with the consumer always ready.
    base = n_res;
    for (int i = 0; i < 8; i++) begin
      set_cmd(1'b1, W'($urandom), W'($urandom), 3'($urandom));
      step();
      if (i > 0) check("stream_valid", 32'(res_valid), 32'd1);
    end
    cmd_valid = 1'b0;
    step();
    check("stream_valid", 32'(res_valid), 32'd1);
    drain(4);
    check("stream_results", 32'(n_res - base), 32'd8);

    // Consumer toggling every cycle.
    for (int i = 0; i < 40; i++) begin
      set_cmd(1'($urandom_range(0, 1)), W'($urandom), W'($urandom), 3'($urandom));
      res_ready = i[0];
      step();
    end
    drain(12);

    // Full-width product.
    set_cmd(1'b1, 8'd255, 8'd255, 3'd7);
    step();
    cmd_valid = 1'b0;
    step();
    check("max_data", 32'(res_data), 32'd65025);
    drain(4);

    // Asynchronous reset with three queued commands and a held result.
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_cmd(1'b1, W'(i + 20), W'(i + 2), 3'(i + 1));
      step();
    end
    cmd_valid = 1'b0;
    check("pre_rst_count", 32'(count), 32'd3);
    rst_n = 1'b0;
    #1;
    check("arst_count", 32'(count), 32'd0);
    check("arst_valid", 32'(res_valid), 32'd0);
    check("arst_data", 32'(res_data), 32'd0);
    check("arst_ready", 32'(cmd_ready), 32'd1);
    step();
    step();
    rst_n = 1'b1;
    res_ready = 1'b1;
    set_cmd(1'b1, 8'd7, 8'd9, 3'd5);
    step();
    cmd_valid = 1'b0;
    step();
    check("post_rst_valid", 32'(res_valid), 32'd1);
    check("post_rst_data", 32'(res_data), 32'd63);
    check("post_rst_opsel", 32'(res_opsel), 32'd5);
    drain(4);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      set_cmd(1'($urandom_range(0, 3) != 0), W'($urandom), W'($urandom), 3'($urandom));
      res_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    drain(20);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
